fetch_queue: RTL

//   Parametrised prefetching instruction fetch unit. Owns its own fetch PC, issues
//   req/ready memory reads and buffers returned instructions, each tagged with its

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch unit bus: instruction memory read port, decode-side queue head and control.
// master = fetch unit, slave = memory/decode side.
interface fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ack;

  modport master (
    input  en, flush, flush_pc, mem_ready, mem_data, inst_ack,
    output mem_addr, mem_req, inst_out, inst_pc, inst_valid
  );

  modport slave (
    output en, flush, flush_pc, mem_ready, mem_data, inst_ack,
    input  mem_addr, mem_req, inst_out, inst_pc, inst_valid
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: one outstanding memory read, DEPTH-entry tagged FIFO.
// Define FETCH_PIPE_EN to chain back-to-back requests without dropping mem_req.
module fetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             fetch_pc;
  logic [ADDR_W-1:0]             mem_addr_q;
  logic                          mem_req_q;
  logic [CW-1:0]                 count;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [DEPTH-1:0][DATA_W-1:0]  q_data;
  logic [DEPTH-1:0][ADDR_W-1:0]  q_pc;

  logic push, pop, chain;

  assign pop  = (count != '0) && bus.inst_ack && !bus.flush;
  assign push = mem_req_q && bus.mem_ready && (state == REQ) && !bus.flush;

`ifdef FETCH_PIPE_EN
  // Occupancy after this edge's push/pop decides whether another read fits.
  logic [CW:0] occ_nxt;
  assign occ_nxt = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign chain   = bus.en && (occ_nxt < (CW+1)'(DEPTH));
`else
  assign chain   = 1'b0;
`endif

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.inst_out   = q_data[rd_ptr];
  assign bus.inst_pc    = q_pc[rd_ptr];
  assign bus.inst_valid = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_data     <= '0;
      q_pc       <= '0;
    end else if (bus.flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= bus.flush_pc;
      // An in-flight read must still finish on the bus; its data is never queued.
      case (state)
        REQ, DRAIN: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end else begin
            state     <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (push) begin
        q_data[wr_ptr] <= bus.mem_data;
        q_pc[wr_ptr]   <= mem_addr_q;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);

      case (state)
        IDLE: begin
          if (bus.en && (count < FULL)) begin
            mem_addr_q <= fetch_pc;
            mem_req_q  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
            if (chain) begin
              mem_addr_q <= fetch_pc + ADDR_W'(1);
            end else begin
              mem_req_q <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
